// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 inverse cipher. One shared inverse-round datapath is reused for all
// rounds. Round keys are read from an external synchronous BRAM holding rk[0..10], which
// has one cycle of read latency. Valid/ready handshakes are used on both the input and
// output sides.
module aes_inv_round_engine #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KEY_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KEY_AW-1:0] rk_addr,
    input  logic [127:0]      rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StKey10 = 3'd2,
        StRound = 3'd3,
        StFinal = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [KEY_AW-1:0] AddrLast = KEY_AW'(NR);
    localparam logic [KEY_AW-1:0] AddrPrev = KEY_AW'(NR - 1);
    localparam logic [KEY_AW-1:0] AddrNext = KEY_AW'(NR - 2);

    state_e            state_q;
    logic [127:0]      st_q;
    logic [KEY_AW-1:0] rnd_q;
    logic [127:0]      sub_rows;
    logic [127:0]      key_added;
    logic [127:0]      mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as required
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte index is 4*col + row; row r rotates right by r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^
                               gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
            o[119-32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^
                               gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
            o[111-32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^
                               gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
            o[103-32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^
                               gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
        end
        return o;
    endfunction

    // Shared inverse-round datapath; the final round simply skips the mix step
    always_comb begin
        sub_rows  = inv_sub_bytes(inv_shift_rows(st_q));
        key_added = sub_rows ^ rk_data;
        mixed     = inv_mix_columns(key_added);
    end

    // Control FSM with registered handshake, address and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            st_q      <= '0;
            rnd_q     <= '0;
            rk_addr   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        st_q     <= in_data;
                        rk_addr  <= AddrLast;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StAddr;
                    end
                end
                // rk[10] read is in flight this cycle
                StAddr: begin
                    rk_addr <= AddrPrev;
                    state_q <= StKey10;
                end
                StKey10: begin
                    st_q    <= st_q ^ rk_data;
                    rk_addr <= AddrNext;
                    rnd_q   <= AddrPrev;
                    state_q <= StRound;
                end
                // Address runs two ahead of the round using it; pin at 0 for the final round
                StRound: begin
                    st_q    <= mixed;
                    rk_addr <= (rnd_q >= KEY_AW'(2)) ? rnd_q - KEY_AW'(2) : '0;
                    rnd_q   <= rnd_q - KEY_AW'(1);
                    if (rnd_q == KEY_AW'(1)) state_q <= StFinal;
                end
                StFinal: begin
                    out_data  <= key_added;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Directed bench for aes_inv_round_engine using FIPS-197 vectors. A small BRAM model serves
// two expanded key schedules; the expected plaintexts are the published constants.
module tb_aes_inv_round_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] sched [2][16];
    int           bank   = 0;
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_round_engine #(
        .NR     (10),
        .KEY_AW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Round-key BRAM with one cycle of read latency
    always @(posedge clk) rk_data <= sched[bank][rk_addr];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box for the key schedule: field inverse then affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] v;
        sq = b;
        v  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            v  = gf_mul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
               {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key, input int b);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = {t[23:0], t[31:24]};
                t    = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t    = t ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[b][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offer one block, wait for the result (bounded), check latency and data, then drain it
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = ct;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'd13);
        check({tag, "_data"}, out_data, pt);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        int   n;
        int   rise1;
        int   rise2;
        logic prev;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) sched[b][a] = '0;
        expand(Key1, 0);
        expand(Key2, 1);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rk_addr", 128'(rk_addr), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd1);

        // T1 with junk offered while busy, a stray out_ready pulse and the key address trace
        @(posedge clk); #1;
        bank     = 0;
        in_valid = 1'b1;
        in_data  = Ct1;
        @(posedge clk);
        for (int j = 1; j <= 13; j++) begin
            #1;
            if (j <= 12) begin
                in_valid = 1'b1;
                in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (j == 5);
            @(negedge clk);
            if (j <= 11) check("t4_rk_addr", 128'(rk_addr), 128'(11 - j));
            if (j <= 12) begin
                check("t4_busy", 128'(busy), 128'd1);
                check("t4_in_ready", 128'(in_ready), 128'd0);
                check("t1_early_valid", 128'(out_valid), 128'd0);
            end else begin
                check("t1_latency", 128'(out_valid), 128'd1);
                check("t1_data", out_data, Pt1);
                check("t1_busy_low", 128'(busy), 128'd0);
            end
            @(posedge clk);
        end

        // T3 backpressure: result held for 20 cycles, new input refused
        #1;
        in_valid = 1'b1;
        in_data  = Ct2;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("t3_valid_hold", 128'(out_valid), 128'd1);
            check("t3_data_hold", out_data, Pt1);
            check("t3_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t3_valid_drop", 128'(out_valid), 128'd0);
        check("t3_idle", 128'(in_ready), 128'd1);
        check("t3_busy", 128'(busy), 128'd0);

        // T5 reset in the rnd=5 round
        @(posedge clk); #1;
        bank     = 1;
        in_valid = 1'b1;
        in_data  = Ct2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t5_mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 128'(out_valid), 128'd0);
        check("t5_rst_in_ready", 128'(in_ready), 128'd1);
        check("t5_rst_busy", 128'(busy), 128'd0);
        check("t5_rst_out_data", out_data, 128'd0);
        check("t5_rst_rk_addr", 128'(rk_addr), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_partial", 128'(seen), 128'd0);
        check("t5_in_ready", 128'(in_ready), 128'd1);
        run_block(Ct2, Pt2, "t2");

        // T6 back-to-back with in_valid and out_ready held high
        @(posedge clk); #1;
        bank      = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = Ct1;
        n     = 0;
        rise1 = -1;
        rise2 = -1;
        prev  = 1'b0;
        while (rise2 < 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (out_valid && !prev) begin
                if (rise1 < 0) begin
                    rise1 = n;
                    check("t6_first", out_data, Pt1);
                    bank    = 1;
                    in_data = Ct2;
                end else begin
                    rise2 = n;
                    check("t6_second", out_data, Pt2);
                    in_valid = 1'b0;
                end
            end
            prev = out_valid;
        end
        check("t6_spacing", 128'(rise2 - rise1), 128'd14);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t6_idle", 128'(in_ready), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
